// File: rtl/hex_inv_selftest_ctrl.sv
// Self-test sequencer that sweeps every code through a hex inverter and checks Y == ~A.
// Optional macro HEX_INV_SELFTEST_STOP_ON_FAIL_EN ends the sweep at the first mismatching code.
module hex_inv_selftest_ctrl #(
    parameter int WIDTH  = 6,
    parameter int SETTLE = 2,
    parameter int ERR_W  = 8
) (
    input  logic             CLK,
    input  logic             CLR_n,
    input  logic             START,
    input  logic             ABORT,
    output logic [WIDTH-1:0] DUT_A,
    input  logic [WIDTH-1:0] DUT_Y,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic             FAIL_VALID,
    output logic [WIDTH-1:0] FIRST_FAIL
);

    localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   dut_a_q, dut_a_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               fv_q, fv_d;
    logic [WIDTH-1:0]   ff_q, ff_d;
    logic               mismatch_s;
    logic               last_code_s;

    assign mismatch_s  = (DUT_Y != ~dut_a_q);
    assign last_code_s = &dut_a_q;

    // State and result registers; CLR_n discards any partial sweep immediately.
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            state_q <= ST_IDLE;
            dut_a_q <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            err_q   <= {ERR_W{1'b0}};
            fv_q    <= 1'b0;
            ff_q    <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            dut_a_q <= dut_a_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            ff_q    <= ff_d;
        end
    end

    // Next-state logic; ABORT overrides everything, including a simultaneous START.
    always_comb begin
        state_d = state_q;
        dut_a_d = dut_a_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fv_d    = fv_q;
        ff_d    = ff_q;
        if (ABORT) begin
            state_d = ST_IDLE;
            dut_a_d = {WIDTH{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        dut_a_d = {WIDTH{1'b0}};
                        err_d   = {ERR_W{1'b0}};
                        fv_d    = 1'b0;
                        ff_d    = {WIDTH{1'b0}};
                        cnt_d   = CNT_W'(SETTLE);
                        state_d = ST_WAIT;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_CHECK;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (mismatch_s) begin
                        if (err_q != {ERR_W{1'b1}}) begin
                            err_d = err_q + ERR_W'(1);
                        end else begin
                            err_d = err_q;
                        end
                        if (!fv_q) begin
                            ff_d = dut_a_q;
                            fv_d = 1'b1;
                        end else begin
                            ff_d = ff_q;
                        end
                    end else begin
                        err_d = err_q;
                    end
`ifdef HEX_INV_SELFTEST_STOP_ON_FAIL_EN
                    if (mismatch_s || last_code_s) begin
`else
                    if (last_code_s) begin
`endif
                        state_d = ST_DONE;
                    end else begin
                        dut_a_d = dut_a_q + WIDTH'(1);
                        cnt_d   = CNT_W'(SETTLE);
                        state_d = ST_WAIT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign DUT_A      = dut_a_q;
    assign BUSY       = (state_q == ST_WAIT) || (state_q == ST_CHECK);
    assign DONE       = (state_q == ST_DONE);
    assign PASS       = (state_q == ST_DONE) && (err_q == {ERR_W{1'b0}});
    assign ERR_CNT    = err_q;
    assign FAIL_VALID = fv_q;
    assign FIRST_FAIL = ff_q;

endmodule

// File: tb/tb_hex_inv_selftest_ctrl.sv
// Bench for hex_inv_selftest_ctrl with a behavioural inverter that can carry stuck-at faults.
module tb_hex_inv_selftest_ctrl;

    logic       CLK, CLR_n, START, ABORT;
    logic [5:0] DUT_A, DUT_Y;
    logic       BUSY, DONE, PASS, FAIL_VALID;
    logic [7:0] ERR_CNT;
    logic [5:0] FIRST_FAIL;
    int         fault_mode;
    int         n_checks = 0;
    int         n_pass   = 0;

    hex_inv_selftest_ctrl #(.WIDTH(6), .SETTLE(2), .ERR_W(8)) dut (
        .CLK(CLK), .CLR_n(CLR_n), .START(START), .ABORT(ABORT),
        .DUT_A(DUT_A), .DUT_Y(DUT_Y), .BUSY(BUSY), .DONE(DONE), .PASS(PASS),
        .ERR_CNT(ERR_CNT), .FAIL_VALID(FAIL_VALID), .FIRST_FAIL(FIRST_FAIL)
    );

    // Inverter model: 0 good, 1 Y[3] stuck at 0, 2 Y[0] stuck at 1.
    always_comb begin
        DUT_Y = ~DUT_A;
        if (fault_mode == 1) DUT_Y[3] = 1'b0;
        else if (fault_mode == 2) DUT_Y[0] = 1'b1;
    end

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " DUT_A"}, int'(DUT_A), 0);
        chk({tag, " BUSY"}, int'(BUSY), 0);
        chk({tag, " DONE"}, int'(DONE), 0);
        chk({tag, " PASS"}, int'(PASS), 0);
        chk({tag, " ERR_CNT"}, int'(ERR_CNT), 0);
        chk({tag, " FAIL_VALID"}, int'(FAIL_VALID), 0);
        chk({tag, " FIRST_FAIL"}, int'(FIRST_FAIL), 0);
    endtask

    // Pulses START for one edge, then counts edges until DONE (bounded).
    task automatic run_sweep(output int cycles);
        START = 1'b1;
        tick();
        START = 1'b0;
        cycles = 0;
        while (!DONE && cycles < 1000) begin
            tick();
            cycles++;
        end
    endtask

    typedef struct {
        string name;
        int    fault;
        int    cycles;
        int    err;
        int    pass;
        int    fv;
        int    ff;
        int    dut_a;
    } vec_t;

    vec_t vecs[3];
    int   cyc;

    initial begin
        vecs[0] = '{"good",      0, 192,  0, 1, 0, 0, 63};
`ifdef HEX_INV_SELFTEST_STOP_ON_FAIL_EN
        vecs[1] = '{"y3_stuck0", 1,   3,  1, 0, 1, 0,  0};
        vecs[2] = '{"y0_stuck1", 2,   6,  1, 0, 1, 1,  1};
`else
        vecs[1] = '{"y3_stuck0", 1, 192, 32, 0, 1, 0, 63};
        vecs[2] = '{"y0_stuck1", 2, 192, 32, 0, 1, 1, 63};
`endif

        CLR_n = 1'b0; START = 1'b0; ABORT = 1'b0; fault_mode = 0;
        tick();
        tick();
        chk_all_zero("reset");
        CLR_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk_all_zero("idle5");

        // Consecutive sweeps also exercise a direct restart from DONE.
        for (int v = 0; v < 3; v++) begin
            fault_mode = vecs[v].fault;
            run_sweep(cyc);
            chk({vecs[v].name, " cycles"}, cyc, vecs[v].cycles);
            chk({vecs[v].name, " DONE"}, int'(DONE), 1);
            chk({vecs[v].name, " BUSY"}, int'(BUSY), 0);
            chk({vecs[v].name, " PASS"}, int'(PASS), vecs[v].pass);
            chk({vecs[v].name, " ERR_CNT"}, int'(ERR_CNT), vecs[v].err);
            chk({vecs[v].name, " FAIL_VALID"}, int'(FAIL_VALID), vecs[v].fv);
            chk({vecs[v].name, " FIRST_FAIL"}, int'(FIRST_FAIL), vecs[v].ff);
            chk({vecs[v].name, " DUT_A"}, int'(DUT_A), vecs[v].dut_a);
            tick();
            chk({vecs[v].name, " DONE held"}, int'(DONE), 1);
        end

        // START while busy is ignored.
        fault_mode = 0;
        START = 1'b1;
        tick();
        START = 1'b0;
        cyc = 0;
        while (!DONE && cyc < 1000) begin
            START = (cyc == 10);
            if (cyc == 10) chk("busy at 10", int'(BUSY), 1);
            tick();
            cyc++;
        end
        START = 1'b0;
        chk("restart ignored cycles", cyc, 192);
        chk("restart ignored PASS", int'(PASS), 1);

        // ABORT mid-sweep, with a simultaneous START that must lose.
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 50; i++) tick();
        chk("pre-abort BUSY", int'(BUSY), 1);
        ABORT = 1'b1;
        START = 1'b1;
        tick();
        ABORT = 1'b0;
        START = 1'b0;
        chk("abort BUSY", int'(BUSY), 0);
        chk("abort DONE", int'(DONE), 0);
        chk("abort PASS", int'(PASS), 0);
        chk("abort DUT_A", int'(DUT_A), 0);
        tick();
        chk("abort stays idle", int'(BUSY), 0);

        // Asynchronous clear mid-sweep, then a clean full sweep.
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        chk("pre-clr DUT_A", int'(DUT_A), 10);
        #2;
        CLR_n = 1'b0;
        #1;
        chk_all_zero("async clr");
        tick();
        CLR_n = 1'b1;
        tick();
        run_sweep(cyc);
        chk("post-clr cycles", cyc, 192);
        chk("post-clr PASS", int'(PASS), 1);
        chk("post-clr ERR_CNT", int'(ERR_CNT), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
